// File: rtl/fft_ctrl_pkg.sv
// Shared types and defaults for the FFT frame sequencer.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_UNLOAD = 2'd3
  } state_e;

  localparam int unsigned NPT_DEF      = 128;
  localparam int unsigned CORE_LAT_DEF = 12;
  localparam int unsigned DW_DEF       = 32;
  localparam int unsigned CW_DEF       = 16;

  // Beat counter must index 0..NPT-1 in LOAD/UNLOAD and 0..CORE_LAT-1 in FLUSH.
  function automatic int unsigned cnt_width(input int unsigned npt, input int unsigned lat);
    int unsigned w;
    w = $clog2(npt);
    if ($clog2(lat) > w) w = $clog2(lat);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the streaming FFT core: loads NPT samples, flushes the
// core pipeline for CORE_LAT beats, then streams NPT results with backpressure.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | core held in reset, waiting for the first input sample
//   ST_LOAD   | accepting NPT input samples into the core
//   ST_FLUSH  | pushing zeros to advance the core through its latency
//   ST_UNLOAD | presenting NPT results, core advances on each acceptance
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned NPT      = NPT_DEF,
  parameter int unsigned CORE_LAT = CORE_LAT_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned CW       = CW_DEF
) (
  input  logic          S_AXI_ACLK,
  input  logic          S_AXI_ARESETN,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          core_en,
  output logic          core_valid,
  output logic [DW-1:0] core_in,
  input  logic [DW-1:0] core_out,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err_last,
  output logic [CW-1:0] frame_cnt
);

  localparam int unsigned CNTW = cnt_width(NPT, CORE_LAT);
  localparam logic [CNTW-1:0] LAST_BEAT  = CNTW'(NPT - 1);
  localparam logic [CNTW-1:0] LAST_FLUSH = (CORE_LAT == 0) ? '0 : CNTW'(CORE_LAT - 1);

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   frame_cnt_q, frame_cnt_d;
  logic            err_last_q, err_last_d;
  logic            done_q, done_d;

  // Next-state, counter and stream/core control decode from the registered state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_last_d  = err_last_q;
    done_d      = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
    core_en     = 1'b0;
    core_valid  = 1'b0;
    core_in     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        core_en    = 1'b1;
        in_ready   = 1'b1;
        core_valid = in_valid;
        core_in    = in_data;
        if (in_valid) begin
          // Frame boundary follows the count; in_last is only cross-checked.
          if (in_last != (cnt_q == LAST_BEAT)) err_last_d = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = (CORE_LAT == 0) ? ST_UNLOAD : ST_FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      ST_FLUSH: begin
        core_en    = 1'b1;
        core_valid = 1'b1;
        if (cnt_q == LAST_FLUSH) begin
          state_d = ST_UNLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_UNLOAD: begin
        core_en    = 1'b1;
        out_valid  = 1'b1;
        out_data   = core_out;
        out_last   = (cnt_q == LAST_BEAT);
        core_valid = out_ready;
        if (out_ready) begin
          if (cnt_q == LAST_BEAT) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + CW'(1);
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over any same-cycle transition; the bus handshake itself still completes.
    if (abort) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      done_d      = 1'b0;
      frame_cnt_d = frame_cnt_q;
    end
  end

  // State, beat counter, frame counter and status flags.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      err_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_last_q  <= err_last_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err_last  = err_last_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl with a behavioral delay-line FFT core.
module tb_fft_frame_ctrl;
  localparam int NPT = 128;
  localparam int LAT = 12;
  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int D   = NPT + LAT;
  localparam logic [DW-1:0] XFORM = 32'h5A5A_3C3C;

  logic          clk, rst_n;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;
  logic          core_en, core_valid;
  logic [DW-1:0] core_in, core_out;
  logic          abort, busy, done, err_last;
  logic [CW-1:0] frame_cnt;

  fft_frame_ctrl #(.NPT(NPT), .CORE_LAT(LAT), .DW(DW), .CW(CW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_en(core_en), .core_valid(core_valid), .core_in(core_in), .core_out(core_out),
    .abort(abort), .busy(busy), .done(done), .err_last(err_last), .frame_cnt(frame_cnt)
  );

  // Core model: result i of a frame emerges after NPT+LAT valid beats, transformed.
  logic [DW-1:0] pipe [D];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !core_en) begin
      for (int i = 0; i < D; i++) pipe[i] <= '0;
    end else if (core_valid) begin
      pipe[0] <= core_in;
      for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign core_out = pipe[D-1] ^ XFORM;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DW:0] sb [$];
  logic [DW:0] mon_e;
  bit mon_en = 0;
  bit bp_mode = 0;
  bit bp_ph = 0;
  int ir_cnt = 0, fl_cnt = 0, ov_cnt = 0, done_cnt = 0, done_cyc = 0, res_idx = 0;
  int start_cyc = 0, ir_b = 0, fl_b = 0, ov_b = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Sink: out_ready=1 normally; in backpressure mode 0,1,0,1... over the result beats.
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode && out_valid) begin
        out_ready = bp_ph;
        bp_ph = ~bp_ph;
      end else begin
        out_ready = 1;
        bp_ph = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every result handshake and checks held results.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (in_ready) ir_cnt++;
      if (busy && core_en && core_valid && !in_ready && !out_valid) fl_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid) begin
        ov_cnt++;
        chk("core_valid_mirrors_ready", {63'd0, core_valid}, {63'd0, out_ready});
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0h expected none", out_data);
        end else begin
          mon_e = sb[0];
          chk("out_data", {32'd0, out_data}, {32'd0, mon_e[DW:1]});
          chk("out_last", {63'd0, out_last}, {63'd0, mon_e[0]});
          if (out_ready) begin
            void'(sb.pop_front());
            res_idx++;
          end
        end
      end
    end
  end

  // Feed one frame of NPT samples; optional input stalls and misplaced in_last.
  task automatic feed(input bit stall, input int bad_last_at, input int seed);
    int idx = 0;
    int n = 0;
    bit err_seen = 0;
    ir_b = ir_cnt;
    fl_b = fl_cnt;
    ov_b = ov_cnt;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    in_valid = 1;
    in_data  = 32'(idx) | (32'(seed) << 16);
    in_last  = (bad_last_at >= 0) ? (idx == bad_last_at) : (idx == NPT - 1);
    while (idx < NPT && n < 2000) begin
      @(negedge clk);
      if (bad_last_at >= 0 && idx == bad_last_at + 1 && !err_seen) begin
        chk("err_last_after_bad_beat", {63'd0, err_last}, 64'd1);
        err_seen = 1;
      end
      if (bad_last_at >= 0 && idx == bad_last_at && in_valid && in_ready)
        chk("err_last_before_bad_beat", {63'd0, err_last}, 64'd0);
      if (in_valid && in_ready) begin
        sb.push_back({in_data ^ XFORM, idx == NPT - 1});
        idx++;
      end
      @(posedge clk);
      #1;
      n++;
      if (idx < NPT) begin
        in_valid = stall ? ((cyc % 7) != 3) : 1'b1;
        in_data  = 32'(idx) | (32'(seed) << 16);
        in_last  = (bad_last_at >= 0) ? (idx == bad_last_at) : (idx == NPT - 1);
      end else begin
        in_valid = 0;
        in_data  = '0;
        in_last  = 0;
      end
    end
    if (idx < NPT) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout: got %0d samples expected %0d", idx, NPT);
    end
  endtask

  task automatic wait_done(input int budget);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", {63'd0, done_cnt != base}, 64'd1);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ctrl"}, {56'd0, in_ready, out_valid, out_last, core_en, core_valid, busy, done, err_last}, 64'd0);
    chk({nm, "_data"}, {out_data, core_in}, 64'd0);
    chk({nm, "_frame_cnt"}, {48'd0, frame_cnt}, 64'd0);
  endtask

  initial begin
    int dc, rb, n;
    rst_n = 1; in_valid = 1; in_data = 32'h1234_5678; in_last = 0; abort = 0;

    // Reset asserted mid-cycle while inputs are active
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #1 chk_reset_outputs("reset_initial");
    repeat (2) @(posedge clk);
    #3 rst_n = 1; in_valid = 0; in_data = '0;
    mon_en = 1;
    repeat (2) @(posedge clk);

    // Frame 1: unstalled ramp
    feed(0, -1, 0);
    wait_done(600);
    chk("f1_done_cycle", 64'(done_cyc - start_cyc), 64'(2*NPT + LAT + 1));
    chk("f1_in_ready_cycles", 64'(ir_cnt - ir_b), 64'(NPT));
    chk("f1_flush_beats", 64'(fl_cnt - fl_b), 64'(LAT));
    chk("f1_frame_cnt", {48'd0, frame_cnt}, 64'd1);
    chk("f1_err_last", {63'd0, err_last}, 64'd0);
    chk("f1_sb_empty", 64'(sb.size()), 64'd0);

    // Frame 2: backpressure during result phase
    bp_mode = 1;
    feed(0, -1, 7);
    wait_done(1000);
    bp_mode = 0;
    chk("f2_unload_cycles", 64'(ov_cnt - ov_b), 64'(2*NPT));
    chk("f2_done_cycle", 64'(done_cyc - start_cyc), 64'(NPT + LAT + 2*NPT + 1));
    chk("f2_frame_cnt", {48'd0, frame_cnt}, 64'd2);
    chk("f2_sb_empty", 64'(sb.size()), 64'd0);

    // Frame 3: in_last at beat 63, with input stalls
    feed(1, 63, 3);
    wait_done(1500);
    chk("f3_frame_cnt", {48'd0, frame_cnt}, 64'd3);
    chk("f3_err_last_sticky", {63'd0, err_last}, 64'd1);
    chk("f3_in_ready_cycles_ge", 64'((ir_cnt - ir_b) >= NPT), 64'd1);
    chk("f3_sb_empty", 64'(sb.size()), 64'd0);

    // Abort on flush beat 5
    feed(0, -1, 5);
    repeat (5) @(posedge clk);
    #1 abort = 1;
    @(posedge clk);
    #1 abort = 0;
    sb.delete();
    @(negedge clk);
    chk("abort_idle", {62'd0, busy, core_en}, 64'd0);
    dc = done_cnt;
    repeat (40) @(posedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(dc));
    chk("abort_frame_cnt", {48'd0, frame_cnt}, 64'd3);

    // Frame 4: clean frame after abort
    feed(0, -1, 9);
    wait_done(600);
    chk("f4_done_cycle", 64'(done_cyc - start_cyc), 64'(2*NPT + LAT + 1));
    chk("f4_frame_cnt", {48'd0, frame_cnt}, 64'd4);
    chk("f4_sb_empty", 64'(sb.size()), 64'd0);

    // Frame 5: asynchronous reset at result 40
    rb = res_idx;
    feed(0, -1, 11);
    n = 0;
    while (res_idx != rb + 40 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk("f5_reached_result_40", 64'(res_idx - rb), 64'd40);
    #3 rst_n = 0;
    #1 chk_reset_outputs("reset_mid_unload");
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;

    // Frame 6: clean frame after reset
    feed(0, -1, 13);
    wait_done(600);
    chk("f6_done_cycle", 64'(done_cyc - start_cyc), 64'(2*NPT + LAT + 1));
    chk("f6_frame_cnt", {48'd0, frame_cnt}, 64'd1);
    chk("f6_err_last", {63'd0, err_last}, 64'd0);
    chk("f6_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
